// File: rtl/opcode_sequencer_pkg.sv
// Shared opcode and state definitions for the decode-stage opcode sequencer.
//   OPCODE_W      : native opcode width
//   OP_*          : architectural and internal-only opcodes
//   S_*           : sequencer state encoding
package opcode_sequencer_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned STATE_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_CALL  = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_CALL2 = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_RET   = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_RET2  = 5'b11011;
    localparam logic [OPCODE_W-1:0] OP_RTI   = 5'b11100;
    localparam logic [OPCODE_W-1:0] OP_RTI2  = 5'b11101;
    localparam logic [OPCODE_W-1:0] OP_INT1  = 5'b11110;
    localparam logic [OPCODE_W-1:0] OP_INT2  = 5'b11111;

    localparam logic [STATE_W-1:0] S_PASS   = 2'd0;
    localparam logic [STATE_W-1:0] S_SECOND = 2'd1;
    localparam logic [STATE_W-1:0] S_INT2   = 2'd2;

endpackage

// File: rtl/opcode_sequencer.sv
// Decode-stage front end driving the control unit opcode.
// Expands CALL/RET/RTI into opcode pairs, injects the two-cycle interrupt
// entry sequence at instruction boundaries, and freezes fetch meanwhile.
// Ports:
//   clk, reset_n (sync, active-low)
//   instr_op, instr_valid : IF/ID opcode and valid
//   intr_req              : external interrupt request
//   stall_in              : downstream stall, freezes this block
//   opCode                : registered opcode to control unit
//   fetch_hold            : combinational freeze of PC and IF/ID
//   intr_ack              : registered pulse when OP_INT1 issues
//   illegal_op            : registered pulse on fetched internal-only opcode
module opcode_sequencer
    import opcode_sequencer_pkg::*;
#(
    parameter int unsigned OPW    = OPCODE_W,
    parameter bit          INT_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] instr_op,
    input  logic           instr_valid,
    input  logic           intr_req,
    input  logic           stall_in,
    output logic [OPW-1:0] opCode,
    output logic           fetch_hold,
    output logic           intr_ack,
    output logic           illegal_op
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [OPW-1:0]     opcode_d;
    logic [OPW-1:0]     second_q, second_d;
    logic               pending_q, pending_d;
    logic               ack_d;
    logic               illegal_d;
    logic               req_en;

    assign req_en = intr_req & INT_EN;

    // Fetch is frozen whenever the sequencer is not consuming the IF/ID opcode.
    assign fetch_hold = stall_in | (state_q != S_PASS) | pending_q;

    // State and registered outputs; reset aborts any in-flight sequence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_PASS;
            opCode     <= OPW'(OP_NOP);
            second_q   <= OPW'(OP_NOP);
            pending_q  <= 1'b0;
            intr_ack   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            opCode     <= opcode_d;
            second_q   <= second_d;
            pending_q  <= pending_d;
            intr_ack   <= ack_d;
            illegal_op <= illegal_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opCode;
        second_d  = second_q;
        pending_d = pending_q | req_en;
        ack_d     = 1'b0;
        illegal_d = 1'b0;

        if (!stall_in) begin
            case (state_q)
                S_PASS: begin
                    if (pending_q) begin
                        // A request landing on the issuing edge merges into this entry.
                        opcode_d  = OPW'(OP_INT1);
                        ack_d     = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_INT2;
                    end else if (!instr_valid) begin
                        opcode_d = OPW'(OP_NOP);
                    end else begin
                        case (instr_op)
                            OPW'(OP_CALL), OPW'(OP_RET), OPW'(OP_RTI): begin
                                opcode_d = instr_op;
                                second_d = instr_op + OPW'(1);
                                state_d  = S_SECOND;
                            end
                            OPW'(OP_CALL2), OPW'(OP_RET2), OPW'(OP_RTI2),
                            OPW'(OP_INT1), OPW'(OP_INT2): begin
                                opcode_d  = OPW'(OP_NOP);
                                illegal_d = 1'b1;
                            end
                            default: opcode_d = instr_op;
                        endcase
                    end
                end
                S_SECOND: begin
                    opcode_d = second_q;
                    state_d  = S_PASS;
                end
                S_INT2: begin
                    opcode_d = OPW'(OP_INT2);
                    state_d  = S_PASS;
                end
                default: begin
                    opcode_d = OPW'(OP_NOP);
                    state_d  = S_PASS;
                end
            endcase
        end
    end

endmodule
